pairing_serdes: RTL and testbench
=================================

// Module: pairing_serdes
// PURPOSE
// - Parametrised serial shim between a narrow host link and a wide GF(3^M) arithmetic core.
// - Gathers one operand word from LANE_W-bit beats and issues a one-cycle core start.
// - Captures the core result on completion and streams it back out in LANE_W-bit beats.
// - Generalises the 1-bit pairing I/O shifter to any lane width, with valid/ready handshakes, beat counting and flush.
// PARAMETERS
// DATA_W   1188  core operand/result width in bits
// LANE_W   4     bits per serial beat (1..DATA_W)
// BEATS    derived localparam = ceil(DATA_W/LANE_W); PAD = BEATS*LANE_W-DATA_W
// PORTS
// clk       in   1       system clock, all logic on posedge
// reset     in   1       asynchronous, active-high; clears all state
// flush     in   1       synchronous abort to LOAD
// s_valid   in   1       input beat valid
// s_ready   out  1       input beat accepted when s_valid&&s_ready
// s_data    in   LANE_W  input beat
// core_in   out  DATA_W  operand word to core, stable START..UNLOAD
// core_start out 1       one-cycle start pulse to core
// core_out  in   DATA_W  core result
// core_done in   1       core completion level; block acts on its 0->1 edge
// m_valid   out  1       output beat valid
// m_ready   in   1       output beat consumed when m_valid&&m_ready
// m_data    out  LANE_W  output beat
// m_last    out  1       high with final output beat
// busy      out  1       high in START, RUN, UNLOAD
// BEHAVIOUR
// - Reset values: state=LOAD, s_ready=1, core_start=0, core_in=0, m_valid=0, m_data=0, m_last=0, busy=0, beat count=0, done_q=0.
// - States: LOAD -> START -> RUN -> UNLOAD -> LOAD.
// - LOAD: s_ready=1; each handshake shifts s_data into a BEATS*LANE_W shift register and increments the beat count.
//   The handshake at count BEATS-1 moves to START and resets the count.
//   core_in is the low DATA_W bits of the register; the top PAD bits of the partial beat are discarded.
// - START: core_start=1 for exactly one cycle, on the cycle after the last input handshake; go to RUN.
// - done_q registers core_done every cycle. The edge (core_done && !done_q) is armed in START and RUN only.
//   On the edge: capture core_out into the output register and go to UNLOAD. A level held high from a previous operation is ignored.
// - UNLOAD: m_valid=1, m_data = current lane. On handshake: shift by LANE_W and increment the beat count.
//   m_last=1 when count==BEATS-1; that handshake returns to LOAD with count 0.
//   m_data/m_last stay stable while m_valid && !m_ready; PAD bits are driven 0.
// - s_ready=0 outside LOAD; s_valid is ignored there. m_ready is ignored outside UNLOAD.
// - flush (after reset in priority): next state LOAD, counts 0, shift registers 0, m_valid=0, core_start=0.
//   The core itself is not aborted; its later done edge is ignored.
// - Async reset mid-operation: outputs take reset values immediately, without a clock edge.
// - Latency: last input handshake -> core_start 1 cycle; done edge -> m_valid 1 cycle.
// CONFIGURATION
// - PAIRING_SERDES_MSB_FIRST_EN defined: both directions are most-significant lane first.
//   The partial lane is the first beat; its top PAD bits are ignored on input and driven 0 on output.
// - Undefined (default): least-significant lane first, partial lane is the last beat.
// TESTING (bench uses DATA_W=10, LANE_W=4, BEATS=3, PAD=2 unless noted)
// 1 reset, beats 0x5,0xA,0x3 -> core_in=10'h3A5; core_start high exactly 1 cycle, the cycle after the 3rd handshake; busy=1.
// 2 core_out=10'h2C7, core_done 0->1 in RUN -> m_data 0x7,0xC,0x2, m_last on 3rd beat only, then s_ready=1.
// 3 m_ready low 5 cycles after 1st output beat -> m_data holds 0xC, no beat lost or repeated.
// 4 flush in RUN -> next cycle s_ready=1, busy=0; a later core_done edge produces no m_valid.
// 5 core_done held high across the load, then START -> no UNLOAD until core_done falls and rises again.
// 6 async reset asserted mid-UNLOAD between clock edges -> m_valid=0, s_ready=1 immediately.
// 7 with PAIRING_SERDES_MSB_FIRST_EN: beats 0x3,0xA,0x5 -> core_in=10'h3A5; core_out=10'h2C7 -> 0x2,0xC,0x7.
// 8 default params: 297 beats in, 297 beats out; random 1188-bit word round-trips via loopback core model.

Source files
------------

// File: rtl/pairing_serdes.sv
// Serial shim between a LANE_W-bit host link and a DATA_W-bit GF(3^M) core.
// Define PAIRING_SERDES_MSB_FIRST_EN for most-significant-lane-first ordering.
module pairing_serdes #(
    parameter int DATA_W = 1188,
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [LANE_W-1:0] s_data,
    output logic [DATA_W-1:0] core_in,
    output logic              core_start,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);
    localparam int BEATS = (DATA_W + LANE_W - 1) / LANE_W;
    localparam int SR_W  = BEATS * LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(BEATS - 2);

    typedef enum logic [1:0] {ST_LOAD, ST_START, ST_RUN, ST_UNLOAD} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_in_sr;
    logic [SR_W-1:0]  r_out_sr;
    logic             r_done_q;
    logic             r_s_ready;
    logic             r_core_start;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_busy;

    logic [SR_W-1:0]  w_in_next;
    logic [SR_W-1:0]  w_out_next;
    logic             w_done_edge;

`ifdef PAIRING_SERDES_MSB_FIRST_EN
    // Partial lane travels first; its PAD bits land above DATA_W and are dropped.
    assign w_in_next  = (r_in_sr << LANE_W) | SR_W'(s_data);
    assign w_out_next = r_out_sr << LANE_W;
    assign m_data     = r_out_sr[SR_W-1 -: LANE_W];
`else
    assign w_in_next  = (r_in_sr >> LANE_W) | (SR_W'(s_data) << (SR_W - LANE_W));
    assign w_out_next = r_out_sr >> LANE_W;
    assign m_data     = r_out_sr[LANE_W-1:0];
`endif

    // A done level left high by an earlier operation must not retrigger capture.
    assign w_done_edge = core_done && !r_done_q;

    assign core_in    = r_in_sr[DATA_W-1:0];
    assign s_ready    = r_s_ready;
    assign core_start = r_core_start;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign busy       = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_LOAD;
            r_cnt        <= '0;
            r_in_sr      <= '0;
            r_out_sr     <= '0;
            r_done_q     <= 1'b0;
            r_s_ready    <= 1'b1;
            r_core_start <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_done_q <= core_done;
            if (flush) begin
                r_state      <= ST_LOAD;
                r_cnt        <= '0;
                r_in_sr      <= '0;
                r_out_sr     <= '0;
                r_s_ready    <= 1'b1;
                r_core_start <= 1'b0;
                r_m_valid    <= 1'b0;
                r_m_last     <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (s_valid && r_s_ready) begin
                            r_in_sr <= w_in_next;
                            if (r_cnt == CNT_LAST) begin
                                r_cnt        <= '0;
                                r_state      <= ST_START;
                                r_s_ready    <= 1'b0;
                                r_busy       <= 1'b1;
                                r_core_start <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    ST_START, ST_RUN: begin
                        r_core_start <= 1'b0;
                        if (w_done_edge) begin
                            r_out_sr  <= SR_W'(core_out);
                            r_state   <= ST_UNLOAD;
                            r_m_valid <= 1'b1;
                            r_m_last  <= (BEATS == 1);
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_UNLOAD: begin
                        if (m_ready) begin
                            r_out_sr <= w_out_next;
                            if (r_cnt == CNT_LAST) begin
                                r_cnt     <= '0;
                                r_state   <= ST_LOAD;
                                r_m_valid <= 1'b0;
                                r_m_last  <= 1'b0;
                                r_s_ready <= 1'b1;
                                r_busy    <= 1'b0;
                            end else begin
                                r_cnt    <= r_cnt + 1'b1;
                                r_m_last <= (r_cnt == CNT_PEN);
                            end
                        end
                    end
                    default: r_state <= ST_LOAD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pairing_serdes.sv
// Scoreboard bench for pairing_serdes: a 10/4 instance for directed cases and a
// default-parameter instance for a full-width loopback round trip.
module tb_pairing_serdes;
    localparam int SD = 10;
    localparam int SL = 4;
    localparam int SB = 3;
    localparam int BD = 1188;
    localparam int BL = 4;
    localparam int BB = 297;

`ifdef PAIRING_SERDES_MSB_FIRST_EN
    localparam logic [3:0] IN_B  [3] = '{4'h3, 4'hA, 4'h5};
    localparam logic [3:0] OUT_B [3] = '{4'h2, 4'hC, 4'h7};
    localparam int PART = 0;
`else
    localparam logic [3:0] IN_B  [3] = '{4'h5, 4'hA, 4'h3};
    localparam logic [3:0] OUT_B [3] = '{4'h7, 4'hC, 4'h2};
    localparam int PART = 2;
`endif

    logic clk = 1'b0;
    logic rst;

    logic          a_flush, a_sv, a_sr, a_cs, a_cd, a_mv, a_mr, a_ml, a_busy;
    logic [SL-1:0] a_sd, a_md;
    logic [SD-1:0] a_ci, a_co;

    logic          b_flush, b_sv, b_sr, b_cs, b_cd, b_mv, b_mr, b_ml, b_busy;
    logic [BL-1:0] b_sd, b_md;
    logic [BD-1:0] b_ci, b_co;

    int n_checks = 0;
    int n_fail   = 0;
    int b_nout   = 0;
    int n;

    logic [4:0]    sm_q[$];
    logic [4:0]    b_q[$];
    logic [4:0]    sm_e, b_e;
    logic [SD-1:0] w_s, r_s;
    logic [3:0]    bt[3];
    logic [BD-1:0] w_b;
    logic [31:0]   c1, c2;

    always #5 clk = ~clk;

    pairing_serdes #(.DATA_W(SD), .LANE_W(SL)) u_small (
        .clk(clk), .reset(rst), .flush(a_flush),
        .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .core_in(a_ci), .core_start(a_cs), .core_out(a_co), .core_done(a_cd),
        .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md), .m_last(a_ml), .busy(a_busy)
    );

    pairing_serdes u_big (
        .clk(clk), .reset(rst), .flush(b_flush),
        .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .core_in(b_ci), .core_start(b_cs), .core_out(b_co), .core_done(b_cd),
        .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md), .m_last(b_ml), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [3:0] sm_beat(input logic [SD-1:0] w, input int i);
        logic [SB*SL-1:0] x;
        x = {2'b00, w};
`ifdef PAIRING_SERDES_MSB_FIRST_EN
        return x[4*(SB-1-i) +: 4];
`else
        return x[4*i +: 4];
`endif
    endfunction

    function automatic logic [3:0] big_beat(input logic [BD-1:0] w, input int i);
`ifdef PAIRING_SERDES_MSB_FIRST_EN
        return w[4*(BB-1-i) +: 4];
`else
        return w[4*i +: 4];
`endif
    endfunction

    // Drives three back-to-back beats, then checks the start pulse and operand.
    task automatic load_small(input logic [3:0] b0, input logic [3:0] b1,
                              input logic [3:0] b2, input logic [SD-1:0] exp_ci);
        step(); a_sv = 1'b1; a_sd = b0; chk("s_ready_beat0", 64'(a_sr), 64'd1);
        step(); a_sd = b1;              chk("s_ready_beat1", 64'(a_sr), 64'd1);
        step(); a_sd = b2;              chk("s_ready_beat2", 64'(a_sr), 64'd1);
        step(); a_sv = 1'b0;
        chk("core_start_on", 64'(a_cs), 64'd1);
        chk("busy_start", 64'(a_busy), 64'd1);
        chk("s_ready_start", 64'(a_sr), 64'd0);
        chk("core_in", 64'(a_ci), 64'(exp_ci));
        step();
        chk("core_start_off", 64'(a_cs), 64'd0);
        chk("core_in_stable", 64'(a_ci), 64'(exp_ci));
    endtask

    task automatic drain_small();
        int k;
        k = 0;
        a_mr = 1'b1;
        while ((sm_q.size() != 0 || a_mv) && k < 40) begin
            step();
            k++;
        end
        chk("sm_beats_left", 64'(sm_q.size()), 64'd0);
        chk("sm_mvalid_after", 64'(a_mv), 64'd0);
        chk("sm_s_ready_after", 64'(a_sr), 64'd1);
        chk("sm_busy_after", 64'(a_busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (a_mv && a_mr) begin
            if (sm_q.size() == 0) begin
                chk("sm_unexpected_beat", 64'(a_mv), 64'd0);
            end else begin
                sm_e = sm_q.pop_front();
                chk("sm_m_data", 64'(a_md), 64'(sm_e[3:0]));
                chk("sm_m_last", 64'(a_ml), 64'(sm_e[4]));
            end
        end
    end

    always @(negedge clk) begin
        if (b_mv && b_mr) begin
            if (b_q.size() == 0) begin
                chk("b_unexpected_beat", 64'(b_mv), 64'd0);
            end else begin
                b_e = b_q.pop_front();
                chk("b_m_data", 64'(b_md), 64'(b_e[3:0]));
                chk("b_m_last", 64'(b_ml), 64'(b_e[4]));
                b_nout++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        a_flush = 0; a_sv = 0; a_sd = '0; a_co = '0; a_cd = 0; a_mr = 0;
        b_flush = 0; b_sv = 0; b_sd = '0; b_co = '0; b_cd = 0; b_mr = 0;
        step(); step();
        chk("rst_s_ready", 64'(a_sr), 64'd1);
        chk("rst_core_start", 64'(a_cs), 64'd0);
        chk("rst_core_in", 64'(a_ci), 64'd0);
        chk("rst_m_valid", 64'(a_mv), 64'd0);
        chk("rst_m_data", 64'(a_md), 64'd0);
        chk("rst_m_last", 64'(a_ml), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_b_s_ready", 64'(b_sr), 64'd1);
        rst = 1'b0;

        // Fixed-pattern load and unload.
        load_small(IN_B[0], IN_B[1], IN_B[2], 10'h3A5);
        a_mr = 1'b1; a_co = 10'h2C7; a_cd = 1'b1;
        for (int i = 0; i < SB; i++) sm_q.push_back({(i == SB - 1), OUT_B[i]});
        step();
        chk("done_to_mvalid", 64'(a_mv), 64'd1);
        drain_small();
        a_cd = 1'b0; step();

        // Output backpressure for five cycles on the second beat.
        load_small(IN_B[0], IN_B[1], IN_B[2], 10'h3A5);
        a_mr = 1'b0; a_co = 10'h2C7; a_cd = 1'b1;
        for (int i = 0; i < SB; i++) sm_q.push_back({(i == SB - 1), OUT_B[i]});
        step();
        chk("bp_mvalid", 64'(a_mv), 64'd1);
        chk("bp_first", 64'(a_md), 64'(OUT_B[0]));
        a_mr = 1'b1; step(); a_mr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", 64'(a_md), 64'(OUT_B[1]));
            chk("bp_hold_valid", 64'(a_mv), 64'd1);
            chk("bp_hold_last", 64'(a_ml), 64'd0);
            step();
        end
        drain_small();
        a_cd = 1'b0; step();

        // Flush during RUN; a later done edge must be ignored.
        load_small(IN_B[0], IN_B[1], IN_B[2], 10'h3A5);
        a_flush = 1'b1; step(); a_flush = 1'b0;
        chk("flush_s_ready", 64'(a_sr), 64'd1);
        chk("flush_busy", 64'(a_busy), 64'd0);
        chk("flush_core_in", 64'(a_ci), 64'd0);
        chk("flush_core_start", 64'(a_cs), 64'd0);
        a_co = 10'h3FF; a_cd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_mvalid", 64'(a_mv), 64'd0);
        end
        a_cd = 1'b0; step();

        // Done held high through the load; only a fresh edge counts.
        w_s = 10'h1B6; r_s = 10'h0E9;
        a_cd = 1'b1; step();
        load_small(sm_beat(w_s, 0), sm_beat(w_s, 1), sm_beat(w_s, 2), w_s);
        a_sv = 1'b1; a_sd = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("held_no_mvalid", 64'(a_mv), 64'd0);
            chk("run_s_ready", 64'(a_sr), 64'd0);
            chk("run_core_in", 64'(a_ci), 64'(w_s));
        end
        a_sv = 1'b0; a_cd = 1'b0; step();
        a_co = r_s; a_cd = 1'b1;
        for (int i = 0; i < SB; i++) sm_q.push_back({(i == SB - 1), sm_beat(r_s, i)});
        step();
        chk("rearm_mvalid", 64'(a_mv), 64'd1);
        drain_small();
        a_cd = 1'b0; step();

        // Asynchronous reset in the middle of UNLOAD.
        load_small(IN_B[0], IN_B[1], IN_B[2], 10'h3A5);
        a_mr = 1'b0; a_co = 10'h1F0; a_cd = 1'b1;
        for (int i = 0; i < SB; i++) sm_q.push_back({(i == SB - 1), sm_beat(10'h1F0, i)});
        step(); step();
        chk("pre_reset_mvalid", 64'(a_mv), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_m_valid", 64'(a_mv), 64'd0);
        chk("async_s_ready", 64'(a_sr), 64'd1);
        chk("async_busy", 64'(a_busy), 64'd0);
        chk("async_m_data", 64'(a_md), 64'd0);
        chk("async_core_in", 64'(a_ci), 64'd0);
        sm_q.delete();
        a_cd = 1'b0;
        step(); rst = 1'b0; step();
        chk("post_reset_s_ready", 64'(a_sr), 64'd1);

        // Random words with junk in the partial lane's pad bits.
        for (int t = 0; t < 4; t++) begin
            w_s = 10'($urandom); r_s = 10'($urandom);
            for (int i = 0; i < SB; i++) bt[i] = sm_beat(w_s, i);
            bt[PART] = bt[PART] | 4'hC;
            load_small(bt[0], bt[1], bt[2], w_s);
            a_co = r_s; a_cd = 1'b1;
            for (int i = 0; i < SB; i++) sm_q.push_back({(i == SB - 1), sm_beat(r_s, i)});
            step();
            chk("rand_mvalid", 64'(a_mv), 64'd1);
            drain_small();
            a_cd = 1'b0; step();
        end

        // Full-width loopback through the default-parameter instance.
        for (int k = 0; k < 37; k++) w_b[32*k +: 32] = $urandom;
        w_b[BD-1 -: 4] = 4'($urandom);
        for (int i = 0; i < BB; i++) b_q.push_back({(i == BB - 1), big_beat(w_b, i)});
        step(); b_sv = 1'b1;
        for (int i = 0; i < BB; i++) begin
            b_sd = big_beat(w_b, i);
            chk("b_s_ready", 64'(b_sr), 64'd1);
            step();
        end
        b_sv = 1'b0;
        chk("b_core_start_on", 64'(b_cs), 64'd1);
        chk("b_busy", 64'(b_busy), 64'd1);
        for (int k = 0; k < 38; k++) begin
            c1 = 32'(b_ci >> (32*k));
            c2 = 32'(w_b >> (32*k));
            chk("b_core_in", 64'(c1), 64'(c2));
        end
        step();
        chk("b_core_start_off", 64'(b_cs), 64'd0);
        step(); step();
        b_co = b_ci; b_cd = 1'b1;
        n = 0;
        while ((b_q.size() != 0 || b_mv) && n < 3000) begin
            b_mr = 1'($urandom);
            step();
            n++;
        end
        chk("b_beats_left", 64'(b_q.size()), 64'd0);
        chk("b_beats_out", 64'(b_nout), 64'(BB));
        chk("b_s_ready_after", 64'(b_sr), 64'd1);
        b_cd = 1'b0; b_mr = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
